i2c_reg_ctrl: RTL and testbench
===============================

# i2c_reg_ctrl

Register-access controller that sequences the simple I2C slave engine into a byte-addressed register port. It decodes the slave's address, RX and TX-done strobes, and maintains an auto-incrementing register pointer. It issues single-cycle writes and synchronous reads to an external register bank. It holds the slave's `stall` input while read data is fetched, so `data_tx` is stable before the slave loads it.

## Interface
- `I2C_ADDR`, default `7'h42`: 7-bit device address this controller responds to.
- `ADDR_W`, default `4`: register pointer width; bank depth is 2^`ADDR_W`.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr_rw` in 8: {7-bit address, R/nW} from the slave.
- `addr_rw_valid_stb` in 1: one-cycle strobe; `addr_rw` is valid.
- `data_rx` in 8: received byte.
- `data_rx_valid_stb` in 1: one-cycle strobe; `data_rx` is valid.
- `data_tx_done_stb` in 1: one-cycle strobe; the current TX byte has been shifted out.
- `error_stb` in 1: slave protocol error.
- `stall` out 1: holds the slave in its stall state.
- `data_tx` out 8: byte the slave loads for transmit.
- `reg_wr_en` out 1: one-cycle write strobe.
- `reg_wr_addr` out `ADDR_W`: write address.
- `reg_wr_data` out 8: write data.
- `reg_rd_addr` out `ADDR_W`: read address.
- `reg_rd_data` in 8: bank read data, valid 1 cycle after `reg_rd_addr`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE
  - PTR: next RX byte is the pointer.
  - WR: RX bytes are data.
  - RD_ISSUE
  - RD_WAIT
  - RD_HOLD: data presented, `stall` low.
  - IGNORE
- `addr_rw_valid_stb` from any state:
  - `addr_rw[7:1]` ≠ `I2C_ADDR` → IGNORE.
  - R/nW = 0 → PTR.
  - R/nW = 1 → RD_ISSUE.
  - This also covers repeated start; the pointer is retained.
- PTR + `data_rx_valid_stb`: `ptr` ← `data_rx[ADDR_W-1:0]`; upper bits are discarded; → WR.
- WR + `data_rx_valid_stb`:
  - `reg_wr_en`=1, `reg_wr_addr`=`ptr`, `reg_wr_data`=`data_rx` on the next cycle.
  - `ptr` ← `ptr`+1, mod 2^`ADDR_W`.
  - Stay in WR.
- RD_ISSUE: `reg_rd_addr`=`ptr`, `stall`=1 → RD_WAIT.
- RD_WAIT: `data_tx` ← `reg_rd_data`, `stall`=1 → RD_HOLD.
- RD_HOLD: `stall`=0.
  - On `data_tx_done_stb`: `ptr` ← `ptr`+1, → RD_ISSUE (prefetch the next byte).
  - The pointer advances even if the master NACKs.
- IGNORE: all RX/TX-done strobes have no effect; leave only on `addr_rw_valid_stb` or `error_stb`.
- `error_stb` in any state → IDLE, `stall`=0, `ptr` retained.
  - It takes priority over simultaneous strobes.
- `data_rx_valid_stb` in IDLE, RD_* or IGNORE: dropped, no write.
- Simultaneous `addr_rw_valid_stb` and `data_rx_valid_stb`: the address strobe wins and the data is dropped.
- `ptr` is never cleared by a STOP; it is cleared only by reset.

## Timing
- Reset values:
  - state IDLE
  - `ptr`=0
  - `stall`=0
  - `data_tx`=8'h00
  - `reg_wr_en`=0
  - `reg_wr_addr`=0
  - `reg_wr_data`=0
  - `reg_rd_addr`=0
  - `busy`=0
- All outputs are registered.
- `stall` rises 1 cycle after `addr_rw_valid_stb` (read) or after `data_tx_done_stb`.
  - It falls 3 cycles after the strobe, in the same cycle `data_tx` holds the new value.
- Write latency: `reg_wr_en` pulses exactly 1 cycle after `data_rx_valid_stb`, for 1 cycle.
- Read latency: `data_tx` is valid 2 cycles after entering RD_ISSUE.
  - `data_tx` does not change while `stall`=0.
- Reset asserted mid-transaction clears immediately (asynchronous); `stall` drops in the same instant.
- Pointer wrap: 2^`ADDR_W`-1 + 1 → 0, for both reads and writes.

## Structure
- Package `i2c_reg_pkg` holds:
  - the state enum (3-bit encoding);
  - the default `I2C_ADDR` constant;
  - the R/nW bit index (0).
- No sub-module inside this block.
- Register storage is the separate `i2c_reg_bank` (2^`ADDR_W`×8, synchronous read), instanced beside it at the top level.

## Test plan
All scenarios use a behavioural bank model.
- Write 0x84, then 0x03, 0xA5, 0x5A → writes reg[3]=0xA5, reg[4]=0x5A; `ptr`=5.
- Write 0x84, 0x07; repeated start with 0x85; two bytes read → TX 0x77, then 0x88 (bank preloaded reg[7]=0x77, reg[8]=0x88).
  - `stall` is high for exactly 2 cycles before each byte.
- Address 0x90 (0x48, write), then 0x02, 0xFF → no `reg_wr_en`; `ptr` unchanged; `busy` stays high until the next address strobe.
- Write 0x84, 0x0F, 0x11, 0x22 (`ADDR_W`=4) → reg[15]=0x11, reg[0]=0x22 (wrap).
- `error_stb` during RD_WAIT → IDLE next cycle, `stall`=0, `ptr` retained.
- Reset asserted while `stall`=1 → `stall`=0 and `data_tx`=0x00 without waiting for a clock edge.

Source files
------------

// File: rtl/i2c_reg_pkg.sv
// i2c_reg_pkg: shared types and constants for the I2C register controller.
// Holds the controller state encoding, default device address, R/nW index.
package i2c_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PTR      = 3'd1,
        ST_WR       = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_HOLD  = 3'd5,
        ST_IGNORE   = 3'd6
    } state_t;

    localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h42;
    localparam int         RW_BIT           = 0;

endpackage

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: sequences an I2C slave engine onto a byte register port.
// Ports: slave strobes/bytes in, stall/data_tx out; bank wr/rd port; busy.
module i2c_reg_ctrl
    import i2c_reg_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = I2C_ADDR_DEFAULT,
    parameter int         ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        addr_rw,
    input  logic              addr_rw_valid_stb,
    input  logic [7:0]        data_rx,
    input  logic              data_rx_valid_stb,
    input  logic              data_tx_done_stb,
    input  logic              error_stb,
    output logic              stall,
    output logic [7:0]        data_tx,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_data,
    output logic [ADDR_W-1:0] reg_rd_addr,
    input  logic [7:0]        reg_rd_data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    assign ptr_nxt = ptr + PTR_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            stall       <= 1'b0;
            data_tx     <= 8'h00;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= 8'h00;
            reg_rd_addr <= '0;
            busy        <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            if (error_stb) begin
                state <= ST_IDLE;
                stall <= 1'b0;
                busy  <= 1'b0;
            end else if (addr_rw_valid_stb) begin
                // Also handles repeated start: ptr is kept as-is.
                busy <= 1'b1;
                if (addr_rw[7:1] != I2C_ADDR) begin
                    state <= ST_IGNORE;
                    stall <= 1'b0;
                end else if (!addr_rw[RW_BIT]) begin
                    state <= ST_PTR;
                    stall <= 1'b0;
                end else begin
                    state       <= ST_RD_ISSUE;
                    stall       <= 1'b1;
                    reg_rd_addr <= ptr;
                end
            end else begin
                unique case (state)
                    ST_PTR: begin
                        if (data_rx_valid_stb) begin
                            ptr   <= data_rx[ADDR_W-1:0];
                            state <= ST_WR;
                        end
                    end
                    ST_WR: begin
                        if (data_rx_valid_stb) begin
                            reg_wr_en   <= 1'b1;
                            reg_wr_addr <= ptr;
                            reg_wr_data <= data_rx;
                            ptr         <= ptr_nxt;
                        end
                    end
                    ST_RD_ISSUE: begin
                        // Bank samples reg_rd_addr at this edge.
                        stall <= 1'b1;
                        state <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: begin
                        data_tx <= reg_rd_data;
                        stall   <= 1'b0;
                        state   <= ST_RD_HOLD;
                    end
                    ST_RD_HOLD: begin
                        // Prefetch next byte; advances even on NACK.
                        if (data_tx_done_stb) begin
                            ptr         <= ptr_nxt;
                            reg_rd_addr <= ptr_nxt;
                            stall       <= 1'b1;
                            state       <= ST_RD_ISSUE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: directed scenarios plus random strobes for i2c_reg_ctrl.
// A transaction-level model and a bench-side register bank check every cycle.
module tb_i2c_reg_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    localparam int M_IDLE = 0;
    localparam int M_PTR  = 1;
    localparam int M_DATA = 2;
    localparam int M_READ = 3;
    localparam int M_IGN  = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    addr_rw;
    logic          addr_rw_valid_stb;
    logic [7:0]    data_rx;
    logic          data_rx_valid_stb;
    logic          data_tx_done_stb;
    logic          error_stb;
    logic          stall;
    logic [7:0]    data_tx;
    logic          reg_wr_en;
    logic [AW-1:0] reg_wr_addr;
    logic [7:0]    reg_wr_data;
    logic [AW-1:0] reg_rd_addr;
    logic [7:0]    reg_rd_data;
    logic          busy;

    logic [7:0] bank [DEPTH];
    logic [7:0] mmem [DEPTH];

    int checks;
    int failures;

    i2c_reg_ctrl #(.I2C_ADDR(7'h42), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .addr_rw           (addr_rw),
        .addr_rw_valid_stb (addr_rw_valid_stb),
        .data_rx           (data_rx),
        .data_rx_valid_stb (data_rx_valid_stb),
        .data_tx_done_stb  (data_tx_done_stb),
        .error_stb         (error_stb),
        .stall             (stall),
        .data_tx           (data_tx),
        .reg_wr_en         (reg_wr_en),
        .reg_wr_addr       (reg_wr_addr),
        .reg_wr_data       (reg_wr_data),
        .reg_rd_addr       (reg_rd_addr),
        .reg_rd_data       (reg_rd_data),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank: synchronous read, one-cycle write.
    always @(posedge clk) begin
        reg_rd_data <= bank[reg_rd_addr];
        if (reg_wr_en) bank[reg_wr_addr] <= reg_wr_data;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: mode, pointer, fetch countdown.
    int         m_mode;
    int         m_ptr;
    int         m_fetch;
    logic [7:0] m_tx;
    logic       m_wr;
    int         m_wa;
    logic [7:0] m_wd;

    initial begin
        logic       s_rst, s_as, s_rs, s_ds, s_er;
        logic [7:0] s_a, s_d;
        m_mode = M_IDLE; m_ptr = 0; m_fetch = 0;
        m_tx = 0; m_wr = 0; m_wa = 0; m_wd = 0;
        forever begin
            @(posedge clk);
            s_rst = rst_n;
            s_as  = addr_rw_valid_stb;
            s_a   = addr_rw;
            s_rs  = data_rx_valid_stb;
            s_d   = data_rx;
            s_ds  = data_tx_done_stb;
            s_er  = error_stb;
            #1;
            if (!s_rst) begin
                m_mode = M_IDLE; m_ptr = 0; m_fetch = 0;
                m_tx = 0; m_wr = 0; m_wa = 0; m_wd = 0;
            end else begin
                m_wr = 0;
                if (s_er) begin
                    m_mode  = M_IDLE;
                    m_fetch = 0;
                end else if (s_as) begin
                    m_fetch = 0;
                    if (s_a[7:1] != 7'h42) m_mode = M_IGN;
                    else if (s_a[0]) begin
                        m_mode  = M_READ;
                        m_fetch = 2;
                    end else m_mode = M_PTR;
                end else if (m_mode == M_PTR) begin
                    if (s_rs) begin
                        m_ptr  = s_d % DEPTH;
                        m_mode = M_DATA;
                    end
                end else if (m_mode == M_DATA) begin
                    if (s_rs) begin
                        m_wr = 1;
                        m_wa = m_ptr;
                        m_wd = s_d;
                        mmem[m_ptr] = s_d;
                        m_ptr = (m_ptr + 1) % DEPTH;
                    end
                end else if (m_mode == M_READ) begin
                    if (m_fetch > 0) begin
                        m_fetch--;
                        if (m_fetch == 0) m_tx = mmem[m_ptr];
                    end else if (s_ds) begin
                        m_ptr   = (m_ptr + 1) % DEPTH;
                        m_fetch = 2;
                    end
                end
            end
            chk("stall", stall, m_fetch > 0);
            chk("busy", busy, m_mode != M_IDLE);
            chk("data_tx", data_tx, m_tx);
            chk("wr_en", reg_wr_en, m_wr);
            chk("wr_addr", reg_wr_addr, m_wa);
            chk("wr_data", reg_wr_data, m_wd);
            if (m_fetch > 0) chk("rd_addr", reg_rd_addr, m_ptr);
        end
    end

    task automatic p_addr(input logic [7:0] b);
        addr_rw = b;
        addr_rw_valid_stb = 1'b1;
        @(negedge clk);
        addr_rw_valid_stb = 1'b0;
    endtask

    task automatic p_rx(input logic [7:0] b);
        data_rx = b;
        data_rx_valid_stb = 1'b1;
        @(negedge clk);
        data_rx_valid_stb = 1'b0;
    endtask

    task automatic p_done();
        data_tx_done_stb = 1'b1;
        @(negedge clk);
        data_tx_done_stb = 1'b0;
    endtask

    task automatic p_err();
        error_stb = 1'b1;
        @(negedge clk);
        error_stb = 1'b0;
    endtask

    task automatic read_byte(input logic [7:0] exp, input string nm);
        int n;
        n = 0;
        while (stall && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_stall_cycles"}, n, 2);
        chk({nm, "_data"}, data_tx, exp);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        addr_rw = 0;
        addr_rw_valid_stb = 0;
        data_rx = 0;
        data_rx_valid_stb = 0;
        data_tx_done_stb = 0;
        error_stb = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bank[i] = {i[3:0], i[3:0]};
            mmem[i] = {i[3:0], i[3:0]};
        end
        repeat (3) @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_data_tx", data_tx, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_rd_addr", reg_rd_addr, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write pointer 3 then two bytes; read back at pointer 5.
        p_addr(8'h84); p_rx(8'h03); p_rx(8'hA5); p_rx(8'h5A);
        repeat (2) @(negedge clk);
        chk("t1_reg3", bank[3], 8'hA5);
        chk("t1_reg4", bank[4], 8'h5A);
        p_addr(8'h85);
        read_byte(8'h55, "t1_ptr5");
        p_err();

        // Pointer 7, repeated start, two-byte read.
        p_addr(8'h84); p_rx(8'h07);
        p_addr(8'h85);
        read_byte(8'h77, "t2_b0");
        p_done();
        read_byte(8'h88, "t2_b1");
        p_done();
        p_err();

        // Foreign address: nothing written, busy until next address.
        p_addr(8'h90); p_rx(8'h02); p_rx(8'hFF);
        repeat (2) @(negedge clk);
        chk("t3_busy", busy, 1);
        chk("t3_reg2", bank[2], 8'h22);
        p_addr(8'h85);
        read_byte(8'h99, "t3_ptr9");

        // Wrap from 15 to 0.
        p_addr(8'h84); p_rx(8'h0F); p_rx(8'h11); p_rx(8'h22);
        repeat (2) @(negedge clk);
        chk("t4_reg15", bank[15], 8'h11);
        chk("t4_reg0", bank[0], 8'h22);
        p_addr(8'h85);
        read_byte(8'h11, "t4_ptr1");

        // Error while waiting on the bank.
        p_done();
        @(negedge clk);
        p_err();
        chk("t5_stall", stall, 0);
        chk("t5_busy", busy, 0);
        chk("t5_tx_held", data_tx, 8'h11);
        p_addr(8'h85);
        read_byte(8'h22, "t5_ptr2");

        // Asynchronous reset while stalled.
        p_done();
        chk("t6_stall_pre", stall, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_stall", stall, 0);
        chk("t6_data_tx", data_tx, 0);
        chk("t6_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random strobes, including collisions.
        for (int c = 0; c < 3000; c++) begin
            addr_rw_valid_stb = ($urandom_range(0, 99) < 6);
            addr_rw = {($urandom_range(0, 3) == 0) ?
                       7'($urandom) : 7'h42, 1'($urandom)};
            data_rx_valid_stb = ($urandom_range(0, 99) < 30);
            data_rx = 8'($urandom);
            data_tx_done_stb = ($urandom_range(0, 99) < 25);
            error_stb = ($urandom_range(0, 99) < 2);
            @(negedge clk);
        end
        addr_rw_valid_stb = 0;
        data_rx_valid_stb = 0;
        data_tx_done_stb = 0;
        error_stb = 0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
